// File: rtl/mips_pkg.sv
// mips_pkg: shared state encodings, opcodes and control codes for the multicycle sequencer.
package mips_pkg;
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EX     = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11,
    S_ERROR    = 4'd12
  } state_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] PC_INC    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts memory wait cycles; expired flags the last permitted wait cycle.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = $clog2(MEM_TIMEOUT + 1);
  logic [W-1:0] count_q, count_d;
  always_comb count_d = clear ? '0 : enable ? count_q + W'(1) : count_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end
  assign expired = count_q == W'(MEM_TIMEOUT - 1);
endmodule

// File: rtl/mips_sequencer.sv
// mips_sequencer: Moore control FSM for a multicycle MIPS datapath with memory
// timeout detection and a retired-instruction counter.
module mips_sequencer
  import mips_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        memto_reg,
  output logic        reg_dst,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  pc_source,
  output logic [3:0]  state,
  output logic        illegal,
  output logic        error,
  output logic [15:0] retired
);
  state_t      state_q, state_d;
  logic [15:0] retired_q, retired_d;
  logic        illegal_q, illegal_d;
  logic        expired, wait_clr, wait_en, retire;
  logic        unused_zero;
  assign unused_zero = zero;
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    state_d = !run ? S_FETCH : mem_ready ? S_DECODE : expired ? S_ERROR : S_FETCH;
      S_DECODE:
        case (opcode)
          OP_RTYPE:     state_d = S_R_EX;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EX;
          default:      state_d = S_FETCH;
        endcase
      S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   state_d = mem_ready ? S_MEM_WB : expired ? S_ERROR : S_MEM_RD;
      S_MEM_WR:   state_d = mem_ready ? S_FETCH : expired ? S_ERROR : S_MEM_WR;
      S_R_EX:     state_d = S_R_WB;
      S_ADDI_EX:  state_d = S_ADDI_WB;
      S_MEM_WB, S_R_WB, S_ADDI_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      default:    state_d = S_ERROR;
    endcase
  end
  // An idle FETCH keeps the timer cleared so the timeout measures only real fetch waits.
  assign wait_clr  = (state_d != state_q) || (state_q == S_FETCH && !run);
  assign wait_en   = (state_q inside {S_MEM_RD, S_MEM_WR} || (state_q == S_FETCH && run)) && !mem_ready;
  assign retire    = state_d == S_FETCH &&
                     state_q inside {S_MEM_WB, S_MEM_WR, S_R_WB, S_ADDI_WB, S_BRANCH, S_JUMP};
  assign retired_d = retired_q + {15'd0, retire};
  assign illegal_d = state_q == S_DECODE && state_d == S_FETCH;
  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (wait_clr),
    .enable  (wait_en),
    .expired (expired)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
    end
  end
  // Outputs are gated by reset so nothing is driven while reset is held.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    memto_reg     = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = ALU_ADD;
    pc_source     = PC_INC;
    if (reset) begin
      case (state_q)
        S_FETCH: if (run) begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE:  alu_src_b = 2'b11;
        S_MEM_ADDR, S_ADDI_EX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEM_WB: begin
          reg_write = 1'b1;
          memto_reg = 1'b1;
        end
        S_MEM_WR: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        S_R_EX: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_FUNCT;
        end
        S_R_WB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        S_ADDI_WB: reg_write = 1'b1;
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = ALU_SUB;
          pc_write_cond = 1'b1;
          pc_source     = PC_BRANCH;
        end
        S_JUMP: begin
          pc_write  = 1'b1;
          pc_source = PC_JUMP;
        end
        default: ;
      endcase
    end
  end
  assign state   = state_q;
  assign illegal = illegal_q;
  assign error   = state_q == S_ERROR;
  assign retired = retired_q;
endmodule

// File: tb/tb_mips_sequencer.sv
// tb_mips_sequencer: directed scenario tests for the multicycle MIPS sequencer.
module tb_mips_sequencer;
  logic        clk, reset, run, zero, mem_ready;
  logic [5:0]  opcode;
  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic        memto_reg, reg_dst, reg_write, alu_src_a, illegal, error;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic [3:0]  state;
  logic [15:0] retired;
  int errs = 0;
  int checks = 0;

  mips_sequencer #(.MEM_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .memto_reg(memto_reg), .reg_dst(reg_dst),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .state(state), .illegal(illegal), .error(error), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_op(input logic [5:0] op);
    opcode = op; run = 1'b1; mem_ready = 1'b1;
    tick();
    run = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0; run = 1'b1; mem_ready = 1'b1; opcode = 6'h00; zero = 1'b0;
    #2;
    checks++; if (state !== 4'd0) begin errs++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (retired !== 16'd0) begin errs++; $display("FAIL reset_retired got=%0d exp=0", retired); end
    checks++; if (error !== 1'b0) begin errs++; $display("FAIL reset_error got=%b exp=0", error); end
    checks++; if (illegal !== 1'b0) begin errs++; $display("FAIL reset_illegal got=%b exp=0", illegal); end
    checks++; if ({mem_read, ir_write, pc_write} !== 3'b000) begin errs++; $display("FAIL reset_outputs got=%b exp=000", {mem_read, ir_write, pc_write}); end
    run = 1'b0;
    #1 reset = 1'b1;
    tick();
    checks++; if (state !== 4'd0) begin errs++; $display("FAIL reset_idle_state got=%0d exp=0", state); end
  endtask

  task automatic test_rtype;
    opcode = 6'b000000; run = 1'b1; mem_ready = 1'b1;
    #1;
    checks++; if ({mem_read, ir_write, pc_write, i_or_d} !== 4'b1110) begin errs++; $display("FAIL fetch_ctrl got=%b exp=1110", {mem_read, ir_write, pc_write, i_or_d}); end
    checks++; if ({alu_src_a, alu_src_b, alu_op, pc_source} !== 7'b0010000) begin errs++; $display("FAIL fetch_alu got=%b exp=0010000", {alu_src_a, alu_src_b, alu_op, pc_source}); end
    tick(); run = 1'b0;
    checks++; if (state !== 4'd1) begin errs++; $display("FAIL rtype_decode_state got=%0d exp=1", state); end
    checks++; if ({alu_src_b, mem_read} !== 3'b110) begin errs++; $display("FAIL decode_ctrl got=%b exp=110", {alu_src_b, mem_read}); end
    tick();
    checks++; if (state !== 4'd6) begin errs++; $display("FAIL rtype_rex_state got=%0d exp=6", state); end
    checks++; if ({alu_src_a, alu_src_b, alu_op} !== 5'b10010) begin errs++; $display("FAIL rex_ctrl got=%b exp=10010", {alu_src_a, alu_src_b, alu_op}); end
    tick();
    checks++; if (state !== 4'd7) begin errs++; $display("FAIL rtype_rwb_state got=%0d exp=7", state); end
    checks++; if ({reg_write, reg_dst, memto_reg} !== 3'b110) begin errs++; $display("FAIL rwb_ctrl got=%b exp=110", {reg_write, reg_dst, memto_reg}); end
    checks++; if (retired !== 16'd0) begin errs++; $display("FAIL rtype_retired_pre got=%0d exp=0", retired); end
    tick();
    checks++; if (state !== 4'd0 || retired !== 16'd1) begin errs++; $display("FAIL rtype_retire got state=%0d retired=%0d exp 0/1", state, retired); end
  endtask

  task automatic test_lw;
    fetch_op(6'b100011);
    tick();
    checks++; if (state !== 4'd2 || {alu_src_a, alu_src_b} !== 3'b110) begin errs++; $display("FAIL lw_memaddr got state=%0d ctrl=%b exp 2/110", state, {alu_src_a, alu_src_b}); end
    mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++; if ({state, mem_read, i_or_d} !== {4'd3, 2'b11}) begin errs++; $display("FAIL lw_wait%0d got state=%0d rd=%b iord=%b exp 3/1/1", i, state, mem_read, i_or_d); end
      tick();
    end
    mem_ready = 1'b1;
    #1;
    checks++; if (state !== 4'd3 || mem_read !== 1'b1) begin errs++; $display("FAIL lw_ready_cycle got state=%0d rd=%b exp 3/1", state, mem_read); end
    tick();
    checks++; if (state !== 4'd4 || {reg_write, memto_reg, reg_dst, mem_read} !== 4'b1100) begin errs++; $display("FAIL lw_memwb got state=%0d ctrl=%b exp 4/1100", state, {reg_write, memto_reg, reg_dst, mem_read}); end
    tick();
    checks++; if (state !== 4'd0 || retired !== 16'd2) begin errs++; $display("FAIL lw_retire got state=%0d retired=%0d exp 0/2", state, retired); end
  endtask

  task automatic test_other_ops;
    fetch_op(6'b101011);
    tick(); tick();
    checks++; if (state !== 4'd5 || {mem_write, reg_write, i_or_d} !== 3'b101) begin errs++; $display("FAIL sw_memwr got state=%0d ctrl=%b exp 5/101", state, {mem_write, reg_write, i_or_d}); end
    tick();
    checks++; if (state !== 4'd0 || retired !== 16'd3) begin errs++; $display("FAIL sw_retire got state=%0d retired=%0d exp 0/3", state, retired); end
    fetch_op(6'b000100); zero = 1'b1;
    tick();
    checks++; if (state !== 4'd8 || {pc_write_cond, pc_source, alu_op, pc_write} !== 6'b101010) begin errs++; $display("FAIL beq_branch got state=%0d ctrl=%b exp 8/101010", state, {pc_write_cond, pc_source, alu_op, pc_write}); end
    tick(); zero = 1'b0;
    checks++; if (state !== 4'd0 || retired !== 16'd4) begin errs++; $display("FAIL beq_retire got state=%0d retired=%0d exp 0/4", state, retired); end
    fetch_op(6'b000010);
    tick();
    checks++; if (state !== 4'd9 || {pc_write, pc_source} !== 3'b110) begin errs++; $display("FAIL jump got state=%0d ctrl=%b exp 9/110", state, {pc_write, pc_source}); end
    tick();
    checks++; if (retired !== 16'd5) begin errs++; $display("FAIL jump_retire got=%0d exp=5", retired); end
    fetch_op(6'b001000);
    tick();
    checks++; if (state !== 4'd10 || {alu_src_a, alu_src_b, alu_op} !== 5'b11000) begin errs++; $display("FAIL addi_ex got state=%0d ctrl=%b exp 10/11000", state, {alu_src_a, alu_src_b, alu_op}); end
    tick();
    checks++; if (state !== 4'd11 || {reg_write, reg_dst, memto_reg} !== 3'b100) begin errs++; $display("FAIL addi_wb got state=%0d ctrl=%b exp 11/100", state, {reg_write, reg_dst, memto_reg}); end
    tick();
    checks++; if (state !== 4'd0 || retired !== 16'd6) begin errs++; $display("FAIL addi_retire got state=%0d retired=%0d exp 0/6", state, retired); end
  endtask

  task automatic test_illegal;
    fetch_op(6'b111111);
    checks++; if (state !== 4'd1 || illegal !== 1'b0) begin errs++; $display("FAIL illegal_decode got state=%0d ill=%b exp 1/0", state, illegal); end
    tick();
    checks++; if (state !== 4'd0 || illegal !== 1'b1 || retired !== 16'd6) begin errs++; $display("FAIL illegal_pulse got state=%0d ill=%b retired=%0d exp 0/1/6", state, illegal, retired); end
    tick();
    checks++; if (illegal !== 1'b0) begin errs++; $display("FAIL illegal_clear got=%b exp=0", illegal); end
  endtask

  task automatic test_ready_race;
    opcode = 6'b000010; run = 1'b1; mem_ready = 1'b0;
    repeat (15) tick();
    checks++; if (state !== 4'd0 || error !== 1'b0) begin errs++; $display("FAIL race_wait got state=%0d err=%b exp 0/0", state, error); end
    mem_ready = 1'b1;
    #1;
    checks++; if (ir_write !== 1'b1) begin errs++; $display("FAIL race_irwrite got=%b exp=1", ir_write); end
    tick(); run = 1'b0;
    checks++; if (state !== 4'd1) begin errs++; $display("FAIL race_decode got=%0d exp=1", state); end
    tick(); tick();
    checks++; if (state !== 4'd0 || retired !== 16'd7) begin errs++; $display("FAIL race_retire got state=%0d retired=%0d exp 0/7", state, retired); end
  endtask

  task automatic test_wrap;
    force dut.retired_q = 16'hFFFF;
    #1 release dut.retired_q;
    fetch_op(6'b000010);
    tick(); tick();
    checks++; if (state !== 4'd0 || retired !== 16'h0000) begin errs++; $display("FAIL wrap got state=%0d retired=%h exp 0/0000", state, retired); end
  endtask

  task automatic test_reset_mid;
    force dut.retired_q = 16'hFFFF;
    #1 release dut.retired_q;
    fetch_op(6'b100011);
    mem_ready = 1'b0;
    tick(); tick();
    checks++; if (state !== 4'd3 || retired !== 16'hFFFF) begin errs++; $display("FAIL mid_memrd got state=%0d retired=%h exp 3/ffff", state, retired); end
    #1 reset = 1'b0;
    #1;
    checks++; if (state !== 4'd0 || retired !== 16'd0) begin errs++; $display("FAIL mid_reset got state=%0d retired=%h exp 0/0000", state, retired); end
    checks++; if ({mem_read, i_or_d} !== 2'b00) begin errs++; $display("FAIL mid_reset_ctrl got=%b exp=00", {mem_read, i_or_d}); end
    run = 1'b0;
    #1 reset = 1'b1;
    tick();
    checks++; if (state !== 4'd0 || retired !== 16'd0) begin errs++; $display("FAIL mid_after got state=%0d retired=%h exp 0/0000", state, retired); end
  endtask

  task automatic test_timeout;
    opcode = 6'b000000; run = 1'b1; mem_ready = 1'b0;
    repeat (16) tick();
    checks++; if (state !== 4'd12 || error !== 1'b1) begin errs++; $display("FAIL timeout got state=%0d err=%b exp 12/1", state, error); end
    checks++; if ({mem_read, ir_write, pc_write, alu_src_b, alu_op, pc_source} !== 9'd0) begin errs++; $display("FAIL timeout_ctrl got=%b exp=0", {mem_read, ir_write, pc_write, alu_src_b, alu_op, pc_source}); end
    mem_ready = 1'b1;
    repeat (2) tick();
    checks++; if (state !== 4'd12 || error !== 1'b1) begin errs++; $display("FAIL error_sticky got state=%0d err=%b exp 12/1", state, error); end
    run = 1'b0;
    #1 reset = 1'b0;
    #1;
    checks++; if (state !== 4'd0 || error !== 1'b0) begin errs++; $display("FAIL error_reset got state=%0d err=%b exp 0/0", state, error); end
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw();
    test_other_ops();
    test_illegal();
    test_ready_race();
    test_wrap();
    test_reset_mid();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/mips_sequencer.md
MIPS_SEQUENCER -- requirements
Module: mips_sequencer

Interface
REQ-001 Parameter: MEM_TIMEOUT, default 16, is the number of consecutive cycles a memory state waits for mem_ready before entering ERROR.
REQ-002 clk  in  1  single clock; all state updates occur on its rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset (asserted at 0).
REQ-004 run  in  1  when 1, FETCH may start a new instruction; when 0, the sequencer idles in FETCH.
REQ-005 opcode  in  6  instr[31:26] from the instruction register.
REQ-006 zero  in  1  ALU zero flag.
REQ-007 mem_ready  in  1  unified memory completes the current read or write in this cycle.
REQ-008 Outputs, all 1 bit unless noted: pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, memto_reg, reg_dst, reg_write, alu_src_a; alu_src_b[1:0], alu_op[1:0], pc_source[1:0].
REQ-009 state  out  4  current state encoding, for debug.
REQ-010 illegal  out  1  one-cycle pulse when DECODE sees an unsupported opcode.
REQ-011 error  out  1  sticky flag for a memory timeout.
REQ-012 retired  out  16  count of completed instructions.

Function
REQ-013 The sequencer shall be a Moore FSM; control outputs depend only on state, plus mem_ready in memory states as noted below.
REQ-014 States and encodings shall be: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EX=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EX=10, ADDI_WB=11, ERROR=12.
REQ-015 FETCH (run=1) shall drive mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; ir_write and pc_write shall be 1 only in the mem_ready cycle; mem_ready=1 moves to DECODE.
REQ-016 DECODE shall drive alu_src_a=0, alu_src_b=11, alu_op=00.
REQ-017 DECODE shall branch on opcode: 000000 to R_EX; 100011 or 101011 to MEM_ADDR; 000100 to BRANCH; 000010 to JUMP; 001000 to ADDI_EX.
REQ-018 Any other opcode in DECODE shall pulse illegal for one cycle, go to FETCH, and leave retired unchanged.
REQ-019 MEM_ADDR shall drive alu_src_a=1, alu_src_b=10, alu_op=00, then go to MEM_RD for lw or MEM_WR for sw.
REQ-020 MEM_RD shall drive mem_read=1, i_or_d=1 and go to MEM_WB on mem_ready; MEM_WB shall drive reg_write=1, memto_reg=1, reg_dst=0.
REQ-021 MEM_WR shall drive mem_write=1, i_or_d=1 and go to FETCH on mem_ready.
REQ-022 R_EX shall drive alu_src_a=1, alu_src_b=00, alu_op=10; R_WB shall drive reg_write=1, reg_dst=1, memto_reg=0.
REQ-023 ADDI_EX shall drive alu_src_a=1, alu_src_b=10, alu_op=00; ADDI_WB shall drive reg_write=1, reg_dst=0, memto_reg=0.
REQ-024 BRANCH shall drive alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01; the PC is updated externally only when zero=1.
REQ-025 JUMP shall drive pc_write=1, pc_source=10.
REQ-026 MEM_WB, MEM_WR (on mem_ready), R_WB, ADDI_WB, BRANCH and JUMP shall return to FETCH.
REQ-027 retired shall increment by 1 on each return to FETCH from a state listed in REQ-026, wrapping 0xFFFF to 0x0000.
REQ-028 Any output not listed for a state shall be 0.
REQ-029 A wait counter shall clear on entry to FETCH, MEM_RD and MEM_WR, and increment each cycle in those states while mem_ready=0.
REQ-030 When the wait counter reaches MEM_TIMEOUT-1 with mem_ready=0, the next state shall be ERROR.
REQ-031 If mem_ready=1 arrives in the same cycle that the timeout is reached, mem_ready shall win.
REQ-032 ERROR shall drive all control outputs to 0, hold error=1, and be left only by reset.
REQ-033 run shall be sampled only in FETCH; deasserting run mid-instruction shall not abort that instruction.

Reset
REQ-034 While reset=0, the sequencer shall immediately go to FETCH, clear error, retired, illegal and the wait counter, and drive all control outputs to 0, independent of clk.
REQ-035 Reset asserted mid-instruction shall abandon the instruction with no retired increment.

Structure
REQ-036 A shared package mips_pkg shall hold the opcode constants, the state encodings, and the alu_op and pc_source codes.
REQ-037 The wait/timeout counter shall be one sub-module, mem_wait_timer (clear, enable, expired).

Verification
REQ-038 R-type: mem_ready=1 in FETCH, opcode=000000 -> 4 cycles FETCH, DECODE, R_EX, R_WB; R_WB has reg_write=1, reg_dst=1; retired 0->1.
REQ-039 lw with mem_ready delayed 3 cycles in MEM_RD -> 5 states, mem_read held for 4 cycles in MEM_RD, MEM_WB has memto_reg=1.
REQ-040 beq, opcode=000100 -> BRANCH has pc_write_cond=1, pc_source=01; sw -> MEM_WR has mem_write=1 and no reg_write.
REQ-041 opcode=111111 -> illegal pulses 1 cycle, back in FETCH, retired unchanged.
REQ-042 mem_ready held 0 for 16 cycles in FETCH -> state=12, error=1, outputs 0; mem_ready then 1 -> stays in ERROR.
REQ-043 reset=0 mid-MEM_RD with retired=0xFFFF -> immediately FETCH, retired=0; separately, 0xFFFF plus one retirement -> 0x0000.
